// File: rtl/fp32_multiplier.sv
// fp32_multiplier: three-stage pipelined IEEE-754 binary32 multiplier.
// Round-to-nearest-even only; subnormal inputs and outputs are flushed to zero.
// Stage 1 unpacks and resolves special operands, stage 2 forms the 48-bit
// significand product, stage 3 normalizes, rounds, saturates and drives the outputs.
module fp32_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        inValid,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        outValid,
    output logic [31:0] outResult,
    output logic [3:0]  outFlags
);

    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [3:0]  FLG_NV = 4'b1000;
    localparam logic [3:0]  FLG_OF = 4'b0100;
    localparam logic [3:0]  FLG_UF = 4'b0010;
    localparam logic [3:0]  FLG_NX = 4'b0001;

    // RNE increment of a 23-bit mantissa; bit 23 of the return is the carry-out.
    function automatic logic [23:0] round_rne(input logic [22:0] man,
                                              input logic        guard,
                                              input logic        sticky);
        logic up;
        up = guard & (sticky | man[0]);
        return {1'b0, man} + {23'd0, up};
    endfunction

    // Range check on the final exponent; returns {flags, result}.
    function automatic logic [35:0] saturate(input logic               sign,
                                             input logic signed [9:0]  exp,
                                             input logic [22:0]        man,
                                             input logic               inexact);
        logic [35:0] r;
        if (exp >= 10'sd255) begin
            r = {FLG_OF | FLG_NX, sign, 8'hFF, 23'd0};
        end else if (exp <= 10'sd0) begin
            r = {FLG_UF | FLG_NX, sign, 31'd0};
        end else begin
            r = {3'b000, inexact, sign, exp[7:0], man};
        end
        return r;
    endfunction

    // ---------------- stage 1: unpack ----------------
    logic              vld_p1_d, vld_p1_q;
    logic              sign_p1_d, sign_p1_q;
    logic signed [9:0] exp_p1_d, exp_p1_q;
    logic [23:0]       sig_a_p1_d, sig_a_p1_q;
    logic [23:0]       sig_b_p1_d, sig_b_p1_q;
    logic              special_p1_d, special_p1_q;
    logic [31:0]       spec_res_p1_d, spec_res_p1_q;
    logic [3:0]        spec_flg_p1_d, spec_flg_p1_q;

    // ---------------- stage 2: multiply ----------------
    logic              vld_p2_d, vld_p2_q;
    logic              sign_p2_d, sign_p2_q;
    logic signed [9:0] exp_p2_d, exp_p2_q;
    logic [47:0]       prod_p2_d, prod_p2_q;
    logic              special_p2_d, special_p2_q;
    logic [31:0]       spec_res_p2_d, spec_res_p2_q;
    logic [3:0]        spec_flg_p2_d, spec_flg_p2_q;

    // ---------------- stage 3: normalize / round (output) ----------------
    logic              vld_p3_d, vld_p3_q;
    logic [31:0]       res_p3_d, res_p3_q;
    logic [3:0]        flg_p3_d, flg_p3_q;

    // Stage 1 combinational signals
    logic [7:0]        exp_a, exp_b;
    logic [22:0]       frac_a, frac_b;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    logic              sign_s1;
    logic signed [9:0] exp_s1;
    logic              special_s1;
    logic [31:0]       spec_res_s1;
    logic [3:0]        spec_flg_s1;

    // Stage 3 combinational signals
    logic [22:0]       man_s3, man_r_s3;
    logic              guard_s3, sticky_s3;
    logic signed [9:0] exp_n_s3, exp_r_s3;
    logic [23:0]       rnd_s3;
    logic [31:0]       res_s3;
    logic [3:0]        flg_s3;

    // Classify operands (exponent 0 is zero regardless of fraction) and pick any special result.
    always_comb begin
        exp_a   = inA[30:23];
        exp_b   = inB[30:23];
        frac_a  = inA[22:0];
        frac_b  = inB[22:0];
        zero_a  = (exp_a == 8'd0);
        zero_b  = (exp_b == 8'd0);
        inf_a   = (exp_a == 8'hFF) && (frac_a == 23'd0);
        inf_b   = (exp_b == 8'hFF) && (frac_b == 23'd0);
        nan_a   = (exp_a == 8'hFF) && (frac_a != 23'd0);
        nan_b   = (exp_b == 8'hFF) && (frac_b != 23'd0);
        snan_a  = nan_a & ~frac_a[22];
        snan_b  = nan_b & ~frac_b[22];
        sign_s1 = inA[31] ^ inB[31];
        exp_s1  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

        special_s1  = 1'b1;
        spec_res_s1 = QNAN;
        spec_flg_s1 = 4'b0000;
        if (nan_a || nan_b) begin
            spec_flg_s1 = (snan_a || snan_b) ? FLG_NV : 4'b0000;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            spec_flg_s1 = FLG_NV;
        end else if (inf_a || inf_b) begin
            spec_res_s1 = {sign_s1, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            spec_res_s1 = {sign_s1, 31'd0};
        end else begin
            special_s1 = 1'b0;
        end
    end

    // Normalize the product, round to nearest even, then apply overflow/underflow.
    always_comb begin
        if (prod_p2_q[47]) begin
            man_s3    = prod_p2_q[46:24];
            guard_s3  = prod_p2_q[23];
            sticky_s3 = |prod_p2_q[22:0];
            exp_n_s3  = exp_p2_q + 10'sd1;
        end else begin
            man_s3    = prod_p2_q[45:23];
            guard_s3  = prod_p2_q[22];
            sticky_s3 = |prod_p2_q[21:0];
            exp_n_s3  = exp_p2_q;
        end
        rnd_s3 = round_rne(man_s3, guard_s3, sticky_s3);
        if (rnd_s3[23]) begin
            man_r_s3 = 23'd0;
            exp_r_s3 = exp_n_s3 + 10'sd1;
        end else begin
            man_r_s3 = rnd_s3[22:0];
            exp_r_s3 = exp_n_s3;
        end
        {flg_s3, res_s3} = saturate(sign_p2_q, exp_r_s3, man_r_s3, guard_s3 | sticky_s3);
        if (special_p2_q) begin
            res_s3 = spec_res_p2_q;
            flg_s3 = spec_flg_p2_q;
        end
    end

    // Next-state for every stage: stall holds all, flush clears valids, else advance.
    always_comb begin
        vld_p1_d      = vld_p1_q;
        vld_p2_d      = vld_p2_q;
        vld_p3_d      = vld_p3_q;
        sign_p1_d     = sign_p1_q;
        exp_p1_d      = exp_p1_q;
        sig_a_p1_d    = sig_a_p1_q;
        sig_b_p1_d    = sig_b_p1_q;
        special_p1_d  = special_p1_q;
        spec_res_p1_d = spec_res_p1_q;
        spec_flg_p1_d = spec_flg_p1_q;
        sign_p2_d     = sign_p2_q;
        exp_p2_d      = exp_p2_q;
        prod_p2_d     = prod_p2_q;
        special_p2_d  = special_p2_q;
        spec_res_p2_d = spec_res_p2_q;
        spec_flg_p2_d = spec_flg_p2_q;
        res_p3_d      = res_p3_q;
        flg_p3_d      = flg_p3_q;
        if (!stall) begin
            if (flush) begin
                vld_p1_d = 1'b0;
                vld_p2_d = 1'b0;
                vld_p3_d = 1'b0;
            end else begin
                vld_p1_d = inValid;
                vld_p2_d = vld_p1_q;
                vld_p3_d = vld_p2_q;
            end
            sign_p1_d     = sign_s1;
            exp_p1_d      = exp_s1;
            sig_a_p1_d    = {1'b1, frac_a};
            sig_b_p1_d    = {1'b1, frac_b};
            special_p1_d  = special_s1;
            spec_res_p1_d = spec_res_s1;
            spec_flg_p1_d = spec_flg_s1;
            sign_p2_d     = sign_p1_q;
            exp_p2_d      = exp_p1_q;
            prod_p2_d     = {24'd0, sig_a_p1_q} * {24'd0, sig_b_p1_q};
            special_p2_d  = special_p1_q;
            spec_res_p2_d = spec_res_p1_q;
            spec_flg_p2_d = spec_flg_p1_q;
            // Output data only moves on a real result, so it reads zero after reset.
            if (!flush && vld_p2_q) begin
                res_p3_d = res_s3;
                flg_p3_d = flg_s3;
            end
        end
    end

    // Valids and the visible output registers reset; everything else is qualified by a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            res_p3_q <= 32'd0;
            flg_p3_q <= 4'd0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            res_p3_q <= res_p3_d;
            flg_p3_q <= flg_p3_d;
        end
    end

    // Stage 1 and stage 2 datapath registers.
    always_ff @(posedge clk) begin
        sign_p1_q     <= sign_p1_d;
        exp_p1_q      <= exp_p1_d;
        sig_a_p1_q    <= sig_a_p1_d;
        sig_b_p1_q    <= sig_b_p1_d;
        special_p1_q  <= special_p1_d;
        spec_res_p1_q <= spec_res_p1_d;
        spec_flg_p1_q <= spec_flg_p1_d;
        sign_p2_q     <= sign_p2_d;
        exp_p2_q      <= exp_p2_d;
        prod_p2_q     <= prod_p2_d;
        special_p2_q  <= special_p2_d;
        spec_res_p2_q <= spec_res_p2_d;
        spec_flg_p2_q <= spec_flg_p2_d;
    end

    assign outValid  = vld_p3_q;
    assign outResult = res_p3_q;
    assign outFlags  = flg_p3_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed vectors against an exact-integer reference model.
module tb_fp32_multiplier;

    logic        clk = 1'b0;
    logic        rst, stall, flush, inValid;
    logic [31:0] inA, inB;
    logic        outValid;
    logic [31:0] outResult;
    logic [3:0]  outFlags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp32_multiplier dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inValid(inValid),
        .inA(inA), .inB(inB),
        .outValid(outValid), .outResult(outResult), .outFlags(outFlags)
    );

    // Directed vectors with hand-computed products and flags {NV,OF,UF,NX}.
    localparam int NV = 17;
    logic [31:0] tv_a [NV] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000,
                               32'h7F800000, 32'hFF800000, 32'h7F800001, 32'h3F800001,
                               32'h3F800003, 32'h7FC00000, 32'h80000000, 32'h00000001,
                               32'hC0400000, 32'h3FFFFFFF, 32'h00800000, 32'h00800000,
                               32'h7F800000};
    logic [31:0] tv_b [NV] = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h00800000,
                               32'h00000000, 32'h40000000, 32'h3F800000, 32'h3FC00000,
                               32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h7F000000,
                               32'h40400000, 32'h3FFFFFFF, 32'h3F800000, 32'h3F000000,
                               32'hFF800000};
    logic [31:0] tv_r [NV] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h00000000,
                               32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h3FC00002,
                               32'h3FC00004, 32'h7FC00000, 32'h80000000, 32'h00000000,
                               32'hC1100000, 32'h407FFFFE, 32'h00800000, 32'h00000000,
                               32'hFF800000};
    logic [3:0]  tv_f [NV] = '{4'h0, 4'h1, 4'h5, 4'h3,
                               4'h8, 4'h0, 4'h8, 4'h1,
                               4'h1, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h1, 4'h0, 4'h3,
                               4'h0};

    // Reference product from the exact integer significand product; returns {flags, result}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, k, sh;
        logic [22:0] fa, fb;
        bit za, zb, ia, ib, na, nb, sna, snb, nx;
        longint unsigned ma, mb, p, keep, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        sna = na && !fa[22];
        snb = nb && !fb[22];
        if (na || nb) return {((sna || snb) ? 4'b1000 : 4'b0000), 32'h7FC00000};
        if ((ia && zb) || (ib && za)) return {4'b1000, 32'h7FC00000};
        if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
        if (za || zb) return {4'b0000, s, 31'd0};
        ma = {40'd0, 1'b1, fa};
        mb = {40'd0, 1'b1, fb};
        p  = ma * mb;
        k  = 0;
        while ((p >> (k + 1)) != 0) k++;
        sh   = k - 23;
        keep = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        e    = ea + eb - 127 + (k - 46);
        nx   = (rem != 0);
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, nx, s, e[7:0], keep[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of in-flight operations: age counts edges since capture; age 3 is on the output.
    int          age_q [$];
    logic [31:0] res_q [$];
    logic [3:0]  flg_q [$];
    bit          rst_seen = 0;
    bit          emitted  = 0;

    always @(posedge clk) begin
        logic [35:0] r;
        if (rst) begin
            age_q.delete();
            res_q.delete();
            flg_q.delete();
            emitted  = 0;
            rst_seen = 1;
        end else if (!stall) begin
            if (flush) begin
                age_q.delete();
                res_q.delete();
                flg_q.delete();
            end else begin
                if (age_q.size() > 0 && age_q[0] == 3) begin
                    void'(age_q.pop_front());
                    void'(res_q.pop_front());
                    void'(flg_q.pop_front());
                end
                for (int i = 0; i < age_q.size(); i++) age_q[i] = age_q[i] + 1;
                if (inValid) begin
                    r = ref_mul(inA, inB);
                    age_q.push_back(1);
                    res_q.push_back(r[31:0]);
                    flg_q.push_back(r[35:32]);
                end
                if (age_q.size() > 0 && age_q[0] == 3) emitted = 1;
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        bit ev;
        if (rst_seen) begin
            ev = (age_q.size() > 0) && (age_q[0] == 3);
            chk("outValid", {31'd0, outValid}, {31'd0, ev});
            if (ev) begin
                chk("outResult", outResult, res_q[0]);
                chk("outFlags", {28'd0, outFlags}, {28'd0, flg_q[0]});
            end else if (!emitted) begin
                chk("idle_result_zero", outResult, 32'd0);
                chk("idle_flags_zero", {28'd0, outFlags}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        inValid = 1'b1;
        inA     = a;
        inB     = b;
        tick();
        inValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] m;
        int          cnt;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; inValid = 1'b0; inA = '0; inB = '0;

        // Pin the reference model to the hand-computed vectors.
        for (int i = 0; i < NV; i++) begin
            m = ref_mul(tv_a[i], tv_b[i]);
            chk($sformatf("model_res[%0d]", i), m[31:0], tv_r[i]);
            chk($sformatf("model_flg[%0d]", i), {28'd0, m[35:32]}, {28'd0, tv_f[i]});
        end

        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", {31'd0, outValid}, 32'd0);
        chk("reset_result", outResult, 32'd0);
        chk("reset_flags", {28'd0, outFlags}, 32'd0);
        tick(); tick();

        // Latency: the result is visible after the third edge counting the capture edge.
        issue(32'h3FC00000, 32'h40000000);
        chk("lat_edge1", {31'd0, outValid}, 32'd0);
        tick();
        chk("lat_edge2", {31'd0, outValid}, 32'd0);
        tick();
        chk("lat_edge3", {31'd0, outValid}, 32'd1);
        chk("basic_result", outResult, 32'h40400000);
        chk("basic_flags", {28'd0, outFlags}, 32'd0);
        tick();
        chk("lat_single_pulse", {31'd0, outValid}, 32'd0);
        repeat (2) tick();

        // All directed vectors back to back.
        for (int i = 0; i < NV; i++) issue(tv_a[i], tv_b[i]);
        repeat (4) tick();

        // Four ops with a 2-cycle stall while the first result is on the output.
        issue(32'h40000000, 32'h40000000);
        issue(32'h40400000, 32'h40000000);
        issue(32'h3F800000, 32'h3F800000);
        stall = 1'b1; inValid = 1'b1; inA = 32'h12345678; inB = 32'h3F800000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_hold_valid", {31'd0, outValid}, 32'd1);
            chk("stall_hold_result", outResult, 32'h40800000);
        end
        stall = 1'b0; inValid = 1'b0;
        issue(32'h40800000, 32'h3F000000);
        repeat (4) tick();

        // Flush with two ops in flight and a third at the input: nothing emerges.
        cnt = 0;
        issue(32'h40000000, 32'h40400000);
        cnt += int'(outValid);
        issue(32'h40400000, 32'h40400000);
        cnt += int'(outValid);
        flush = 1'b1;
        issue(32'h40800000, 32'h40400000);
        flush = 1'b0;
        cnt += int'(outValid);
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(outValid);
        end
        chk("flush_dropped", cnt, 0);

        // Stall and flush together: the flush is ignored and both ops emerge.
        cnt = 0;
        issue(32'h3F800000, 32'h40000000);
        issue(32'h40000000, 32'hC0000000);
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += int'(outValid);
        end
        chk("stall_beats_flush", cnt, 2);

        // Reset with three ops in flight drops all of them.
        issue(32'h40000000, 32'h40000000);
        issue(32'h40400000, 32'h40400000);
        rst = 1'b1;
        issue(32'h3FC00000, 32'h3FC00000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_valid", {31'd0, outValid}, 32'd0);
            chk("rst_mid_result", outResult, 32'd0);
            chk("rst_mid_flags", {28'd0, outFlags}, 32'd0);
            tick();
        end

        // Pipeline still works after the mid-stream reset.
        issue(32'hC0400000, 32'h40400000);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
